// File: rtl/i2s_sample_feeder.sv
// Stereo sample FIFO feeding the I2S transmitter: primes, pops one L/R pair per frame_req, handles underrun/mute.
// Optional I2S_FEEDER_UNDERRUN_CNT_EN adds a saturating underrun_count output.
module i2s_sample_feeder #(
    parameter int DATA_W        = 24,
    parameter int DEPTH         = 8,
    parameter int ADDR_W        = 3,
    parameter int PRIME_LEVEL   = 4,
    parameter int UNDERRUN_HOLD = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    input  logic              frame_req,
    input  logic              mute,
    output logic [DATA_W-1:0] left_word,
    output logic [DATA_W-1:0] right_word,
    output logic              word_valid,
    output logic [ADDR_W:0]   fill_level,
    output logic              underrun,
`ifdef I2S_FEEDER_UNDERRUN_CNT_EN
    output logic [15:0]       underrun_count,
`endif
    input  logic              underrun_clr
);
    typedef enum logic {ST_PRIME, ST_RUN} state_t;

    localparam logic [ADDR_W:0]   L_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   L_PRIME = (ADDR_W+1)'(PRIME_LEVEL);
    localparam logic [ADDR_W-1:0] L_ONE   = ADDR_W'(1);

    logic [DATA_W-1:0] r_mem_l [DEPTH];
    logic [DATA_W-1:0] r_mem_r [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    state_t            r_state;
    logic [DATA_W-1:0] r_last_l, r_last_r;
    logic [DATA_W-1:0] r_left_word, r_right_word;
    logic              r_word_valid, r_underrun;
    logic              w_push, w_pop, w_urun_ev;

    assign s_ready    = (r_count != L_DEPTH);
    assign w_push     = s_valid && s_ready;
    assign w_pop      = frame_req && (r_state == ST_RUN) && (r_count != '0);
    // No bypass: a frame hitting an empty FIFO is an underrun even if a pair is being pushed.
    assign w_urun_ev  = frame_req && (r_state == ST_RUN) && (r_count == '0);

    assign left_word  = r_left_word;
    assign right_word = r_right_word;
    assign word_valid = r_word_valid;
    assign fill_level = r_count;
    assign underrun   = r_underrun;

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_l[r_wr_ptr] <= s_left;
            r_mem_r[r_wr_ptr] <= s_right;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_state      <= ST_PRIME;
            r_last_l     <= '0;
            r_last_r     <= '0;
            r_left_word  <= '0;
            r_right_word <= '0;
            r_word_valid <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + L_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + L_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            r_word_valid <= frame_req;
            if (w_pop) begin
                r_last_l <= r_mem_l[r_rd_ptr];
                r_last_r <= r_mem_r[r_rd_ptr];
            end
            if (frame_req) begin
                if (w_pop && !mute) begin
                    r_left_word  <= r_mem_l[r_rd_ptr];
                    r_right_word <= r_mem_r[r_rd_ptr];
                end else if (w_urun_ev && (UNDERRUN_HOLD != 0) && !mute) begin
                    r_left_word  <= r_last_l;
                    r_right_word <= r_last_r;
                end else begin
                    r_left_word  <= '0;
                    r_right_word <= '0;
                end
            end

            if (underrun_clr)   r_underrun <= 1'b0;
            else if (w_urun_ev) r_underrun <= 1'b1;

            case (r_state)
                ST_PRIME: if (r_count >= L_PRIME) r_state <= ST_RUN;
                ST_RUN:   if (w_urun_ev)          r_state <= ST_PRIME;
                default:                          r_state <= ST_PRIME;
            endcase
        end
    end

`ifdef I2S_FEEDER_UNDERRUN_CNT_EN
    logic [15:0] r_urun_cnt;
    assign underrun_count = r_urun_cnt;

    always_ff @(posedge clk) begin
        if (reset || underrun_clr)               r_urun_cnt <= '0;
        else if (w_urun_ev && r_urun_cnt != '1)  r_urun_cnt <= r_urun_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_i2s_sample_feeder.sv
// Bench for i2s_sample_feeder: reset/prime vector table, directed corner sequences, then random traffic
// against a queue-based model. Runs a zero-on-underrun and a hold-on-underrun instance side by side.
module tb_i2s_sample_feeder;
    localparam int DW = 24, DEPTH = 8, AW = 3, PL = 4;

    logic          clk = 1'b0, reset = 1'b1;
    logic          s_valid = 1'b0, frame_req = 1'b0, mute = 1'b0, underrun_clr = 1'b0;
    logic [DW-1:0] s_left = '0, s_right = '0;
    logic          s_ready, word_valid, underrun, s_ready_h, word_valid_h, underrun_h;
    logic [DW-1:0] left_word, right_word, left_word_h, right_word_h;
    logic [AW:0]   fill_level, fill_level_h;
`ifdef I2S_FEEDER_UNDERRUN_CNT_EN
    logic [15:0]   underrun_count, underrun_count_h;
`endif

    i2s_sample_feeder #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .PRIME_LEVEL(PL), .UNDERRUN_HOLD(0)) u_dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
        .frame_req(frame_req), .mute(mute), .left_word(left_word), .right_word(right_word),
        .word_valid(word_valid), .fill_level(fill_level), .underrun(underrun),
`ifdef I2S_FEEDER_UNDERRUN_CNT_EN
        .underrun_count(underrun_count),
`endif
        .underrun_clr(underrun_clr));

    i2s_sample_feeder #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .PRIME_LEVEL(PL), .UNDERRUN_HOLD(1)) u_dut_h (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready_h), .s_left(s_left), .s_right(s_right),
        .frame_req(frame_req), .mute(mute), .left_word(left_word_h), .right_word(right_word_h),
        .word_valid(word_valid_h), .fill_level(fill_level_h), .underrun(underrun_h),
`ifdef I2S_FEEDER_UNDERRUN_CNT_EN
        .underrun_count(underrun_count_h),
`endif
        .underrun_clr(underrun_clr));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Reference model: queue of {L,R} pairs plus a running flag.
    logic [2*DW-1:0] q[$];
    bit              m_run, m_wv, m_ur;
    logic [DW-1:0]   m_l, m_r, m_lh, m_rh, m_last_l, m_last_r;
    int              m_cnt;

    function automatic logic [DW-1:0] nl(input int i); return DW'(i); endfunction
    function automatic logic [DW-1:0] nr(input int i); return DW'(0) - DW'(i); endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_run = 0; m_wv = 0; m_ur = 0; m_cnt = 0;
        m_l = '0; m_r = '0; m_lh = '0; m_rh = '0; m_last_l = '0; m_last_r = '0;
    endtask

    task automatic check_all();
        chk("fill_level", 64'(fill_level), 64'(q.size()));
        chk("s_ready", 64'(s_ready), 64'(q.size() != DEPTH));
        chk("word_valid", 64'(word_valid), 64'(m_wv));
        chk("left_word", 64'(left_word), 64'(m_l));
        chk("right_word", 64'(right_word), 64'(m_r));
        chk("underrun", 64'(underrun), 64'(m_ur));
        chk("hold.left_word", 64'(left_word_h), 64'(m_lh));
        chk("hold.right_word", 64'(right_word_h), 64'(m_rh));
        chk("hold.fill/ready/wv/ur", {fill_level_h, s_ready_h, word_valid_h, underrun_h},
            {AW'(0), 4'(q.size()), q.size() != DEPTH, m_wv, m_ur});
`ifdef I2S_FEEDER_UNDERRUN_CNT_EN
        chk("underrun_count", 64'(underrun_count), 64'(m_cnt));
        chk("hold.underrun_count", 64'(underrun_count_h), 64'(m_cnt));
`endif
    endtask

    // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
    task automatic cyc(input bit sv, input logic [DW-1:0] l, input logic [DW-1:0] r,
                       input bit fr, input bit mu, input bit clr, input bit rst);
        bit push, ev, run_n;
        logic [2*DW-1:0] p;
        s_valid = sv; s_left = l; s_right = r; frame_req = fr; mute = mu; underrun_clr = clr; reset = rst;
        if (rst) begin
            model_reset();
        end else begin
            push = sv && (q.size() < DEPTH);
            ev = 0; run_n = m_run; m_wv = fr;
            if (fr) begin
                if (!m_run) begin
                    {m_l, m_r, m_lh, m_rh} = '0;
                end else if (q.size() > 0) begin
                    p = q.pop_front();
                    {m_last_l, m_last_r} = p;
                    {m_l, m_r} = mu ? '0 : p;
                    {m_lh, m_rh} = {m_l, m_r};
                end else begin
                    ev = 1; run_n = 0;
                    {m_l, m_r} = '0;
                    {m_lh, m_rh} = mu ? '0 : {m_last_l, m_last_r};
                end
            end
            if (!m_run && q.size() >= PL) run_n = 1;
            if (push) q.push_back({l, r});
            m_run = run_n;
            m_ur  = clr ? 1'b0 : (ev ? 1'b1 : m_ur);
            m_cnt = clr ? 0 : ((ev && m_cnt < 65535) ? m_cnt + 1 : m_cnt);
        end
        @(posedge clk); #1;
        check_all();
    endtask

    task automatic idle();                 cyc(0, '0, '0, 0, 0, 0, 0);      endtask
    task automatic push(input int i);      cyc(1, nl(i), nr(i), 0, 0, 0, 0); endtask
    task automatic frame(input bit mu);    cyc(0, '0, '0, 1, mu, 0, 0);     endtask

    typedef struct {
        bit sv; int idx; bit fr;
        logic [AW:0] efill; bit erdy; bit ewv; logic [DW-1:0] el; logic [DW-1:0] er; bit eur;
    } vec_t;
    vec_t tbl[11];

    initial begin
        // Power-up: three empty frames stay in PRIME, then prime with 4 pairs and pop the first.
        tbl[0]  = '{0, 0, 1, 4'd0, 1, 1, 24'h0, 24'h0, 0};
        tbl[1]  = '{0, 0, 0, 4'd0, 1, 0, 24'h0, 24'h0, 0};
        tbl[2]  = '{0, 0, 1, 4'd0, 1, 1, 24'h0, 24'h0, 0};
        tbl[3]  = '{0, 0, 1, 4'd0, 1, 1, 24'h0, 24'h0, 0};
        tbl[4]  = '{1, 1, 0, 4'd1, 1, 0, 24'h0, 24'h0, 0};
        tbl[5]  = '{1, 2, 0, 4'd2, 1, 0, 24'h0, 24'h0, 0};
        tbl[6]  = '{1, 3, 0, 4'd3, 1, 0, 24'h0, 24'h0, 0};
        tbl[7]  = '{1, 4, 0, 4'd4, 1, 0, 24'h0, 24'h0, 0};
        tbl[8]  = '{0, 0, 0, 4'd4, 1, 0, 24'h0, 24'h0, 0};
        tbl[9]  = '{0, 0, 1, 4'd3, 1, 1, 24'h000001, 24'hFFFFFF, 0};
        tbl[10] = '{0, 0, 0, 4'd3, 1, 0, 24'h000001, 24'hFFFFFF, 0};

        cyc(0, '0, '0, 0, 0, 0, 1);
        cyc(0, '0, '0, 1, 0, 0, 1);
        chk("reset.word_valid", 64'(word_valid), 64'd0);
        chk("reset.s_ready", 64'(s_ready), 64'd1);

        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].sv, nl(tbl[i].idx), nr(tbl[i].idx), tbl[i].fr, 0, 0, 0);
            chk($sformatf("tbl[%0d].fill", i), 64'(fill_level), 64'(tbl[i].efill));
            chk($sformatf("tbl[%0d].ready", i), 64'(s_ready), 64'(tbl[i].erdy));
            chk($sformatf("tbl[%0d].wv", i), 64'(word_valid), 64'(tbl[i].ewv));
            chk($sformatf("tbl[%0d].words", i), {left_word, right_word}, {tbl[i].el, tbl[i].er});
            chk($sformatf("tbl[%0d].underrun", i), 64'(underrun), 64'(tbl[i].eur));
        end

        // Fill to full, hold off a 9th pair, then a frame frees one slot.
        for (int i = 5; i <= 9; i++) push(i);
        chk("full.fill", 64'(fill_level), 64'd8);
        chk("full.ready", 64'(s_ready), 64'd0);
        cyc(1, nl(99), nr(99), 0, 0, 0, 0);
        chk("full.holdoff.fill", 64'(fill_level), 64'd8);
        cyc(1, nl(99), nr(99), 1, 0, 0, 0);
        chk("full.frame.fill", 64'(fill_level), 64'd7);
        chk("full.frame.ready", 64'(s_ready), 64'd1);
        chk("full.frame.words", {left_word, right_word}, {nl(2), nr(2)});

        // Muted pop at fill 5.
        frame(0); frame(0);
        chk("pre_mute.fill", 64'(fill_level), 64'd5);
        frame(1);
        chk("mute.words", {left_word, right_word}, 48'h0);
        chk("mute.fill", 64'(fill_level), 64'd4);

        // Push and pop together at fill 3, then drain to check order.
        frame(0);
        cyc(1, nl(10), nr(10), 1, 0, 0, 0);
        chk("pushpop.fill", 64'(fill_level), 64'd3);
        chk("pushpop.words", {left_word, right_word}, {nl(7), nr(7)});
        for (int i = 8; i <= 10; i++) begin
            frame(0);
            chk($sformatf("order[%0d]", i), {left_word, right_word}, {nl(i), nr(i)});
        end

        // Underrun on empty in RUN; hold instance repeats pair 10.
        frame(0);
        chk("urun.flag", 64'(underrun), 64'd1);
        chk("urun.words", {left_word, right_word}, 48'h0);
        chk("urun.hold.words", {left_word_h, right_word_h}, {nl(10), nr(10)});
        frame(0);
        chk("urun.prime.hold.words", {left_word_h, right_word_h}, 48'h0);

        // Re-prime, drain, then push+frame on empty: underrun, no bypass, pair stored.
        for (int i = 11; i <= 14; i++) push(i);
        idle();
        for (int i = 0; i < 4; i++) frame(0);
        cyc(1, nl(15), nr(15), 1, 0, 0, 0);
        chk("nobypass.fill", 64'(fill_level), 64'd1);
        chk("nobypass.words", {left_word, right_word}, 48'h0);
        chk("nobypass.hold.words", {left_word_h, right_word_h}, {nl(14), nr(14)});
`ifdef I2S_FEEDER_UNDERRUN_CNT_EN
        chk("count.two", 64'(underrun_count), 64'd2);
`endif
        cyc(0, '0, '0, 0, 0, 1, 0);
        chk("clr.underrun", 64'(underrun), 64'd0);
`ifdef I2S_FEEDER_UNDERRUN_CNT_EN
        chk("clr.count", 64'(underrun_count), 64'd0);
`endif

        // Reset mid-operation with a frame request pending.
        cyc(1, nl(16), nr(16), 1, 0, 0, 1);
        chk("midreset.fill", 64'(fill_level), 64'd0);
        chk("midreset.wv", 64'(word_valid), 64'd0);

        // Random traffic: frame-heavy phase, push-heavy phase, then balanced.
        for (int ph = 0; ph < 3; ph++) begin
            for (int n = 0; n < 1500; n++) begin
                int pp, fp;
                pp = (ph == 0) ? 30 : (ph == 1) ? 75 : 50;
                fp = (ph == 0) ? 55 : (ph == 1) ? 20 : 35;
                cyc($urandom_range(99) < pp, DW'($urandom), DW'($urandom), $urandom_range(99) < fp,
                    $urandom_range(99) < 10, $urandom_range(99) < 4, $urandom_range(999) < 5);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
